// File: rtl/dbm_cfg_sequencer.sv
// Debug-mux select CSR write sequencer: splits a 64-bit DbgMuxSelCsr write into
// a 9-beat (or 1-beat disable) config transfer, then waits for the node's apply-ack.
module dbm_cfg_sequencer #(
    parameter int NUM_DBM     = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        csr_wr_valid,
    input  logic [63:0] csr_wr_data,
    output logic        csr_wr_ready,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic [5:0]  cfg_id,
    output logic [3:0]  cfg_beat,
    output logic [7:0]  cfg_data,
    output logic        cfg_last,
    input  logic        node_ack,
    output logic        busy,
    output logic        done,
    output logic [7:0]  active_idmode,
    output logic [1:0]  status_err,
    input  logic        status_err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic [6:0]  NUM_DBM_W    = 7'(NUM_DBM);

    state_e      state_q;
    logic [47:0] segs_q;
    logic [7:0]  idmode_q;
    logic [15:0] wait_cnt_q;
    logic        csr_wr_ready_q;
    logic        cfg_valid_q;
    logic [5:0]  cfg_id_q;
    logic [3:0]  cfg_beat_q;
    logic [7:0]  cfg_data_q;
    logic        cfg_last_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  active_idmode_q;
    logic [1:0]  err_q;
    logic        unused_rsvd_s;

    // Reserved CSR bits [15:8] carry no meaning for the chain.
    assign unused_rsvd_s = ^csr_wr_data[15:8];

    function automatic logic [7:0] beat_payload(input logic [47:0] segs,
                                                input logic [7:0]  idmode,
                                                input logic [3:0]  beat);
        logic [7:0] p;
        case (beat)
            4'd1:    p = {2'b00, segs[5:0]};
            4'd2:    p = {2'b00, segs[11:6]};
            4'd3:    p = {2'b00, segs[17:12]};
            4'd4:    p = {2'b00, segs[23:18]};
            4'd5:    p = {2'b00, segs[29:24]};
            4'd6:    p = {2'b00, segs[35:30]};
            4'd7:    p = {2'b00, segs[41:36]};
            4'd8:    p = {2'b00, segs[47:42]};
            default: p = idmode;
        endcase
        return p;
    endfunction

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            segs_q          <= 48'd0;
            idmode_q        <= 8'd0;
            wait_cnt_q      <= 16'd0;
            csr_wr_ready_q  <= 1'b1;
            cfg_valid_q     <= 1'b0;
            cfg_id_q        <= 6'd0;
            cfg_beat_q      <= 4'd0;
            cfg_data_q      <= 8'd0;
            cfg_last_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            active_idmode_q <= 8'd0;
            err_q           <= 2'b00;
        end else begin
            done_q <= 1'b0;
            // Clear first; any set below overrides the clear for its bit.
            err_q  <= err_q & ~{2{status_err_clr}};
            case (state_q)
                ST_IDLE: begin
                    if (csr_wr_valid) begin
                        segs_q   <= csr_wr_data[63:16];
                        idmode_q <= csr_wr_data[7:0];
                        if ({1'b0, csr_wr_data[7:2]} >= NUM_DBM_W) begin
                            err_q[1] <= 1'b1;
                        end else begin
                            state_q        <= ST_SEND;
                            busy_q         <= 1'b1;
                            csr_wr_ready_q <= 1'b0;
                            cfg_valid_q    <= 1'b1;
                            cfg_id_q       <= csr_wr_data[7:2];
                            cfg_beat_q     <= 4'd0;
                            cfg_data_q     <= csr_wr_data[7:0];
                            cfg_last_q     <= (csr_wr_data[1:0] == 2'b00);
                        end
                    end
                end
                ST_SEND: begin
                    if (cfg_valid_q && cfg_ready) begin
                        if (cfg_last_q) begin
                            state_q     <= ST_WAIT_ACK;
                            cfg_valid_q <= 1'b0;
                            cfg_last_q  <= 1'b0;
                            wait_cnt_q  <= 16'd0;
                        end else begin
                            cfg_beat_q <= cfg_beat_q + 4'd1;
                            cfg_data_q <= beat_payload(segs_q, idmode_q, cfg_beat_q + 4'd1);
                            cfg_last_q <= (cfg_beat_q == 4'd7);
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (node_ack) begin
                        state_q         <= ST_IDLE;
                        busy_q          <= 1'b0;
                        csr_wr_ready_q  <= 1'b1;
                        done_q          <= 1'b1;
                        active_idmode_q <= idmode_q;
                    end else if (wait_cnt_q == TIMEOUT_LAST) begin
                        state_q        <= ST_IDLE;
                        busy_q         <= 1'b0;
                        csr_wr_ready_q <= 1'b1;
                        err_q[0]       <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    busy_q         <= 1'b0;
                    csr_wr_ready_q <= 1'b1;
                    cfg_valid_q    <= 1'b0;
                    cfg_last_q     <= 1'b0;
                end
            endcase
        end
    end

    assign csr_wr_ready  = csr_wr_ready_q;
    assign cfg_valid     = cfg_valid_q;
    assign cfg_id        = cfg_id_q;
    assign cfg_beat      = cfg_beat_q;
    assign cfg_data      = cfg_data_q;
    assign cfg_last      = cfg_last_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign active_idmode = active_idmode_q;
    assign status_err    = err_q;

endmodule

// File: doc/dbm_cfg_sequencer.md
# dbm_cfg_sequencer

Sequences debug-mux select CSR writes into the daisy-chained debug mux nodes. A 64-bit write in the DbgMuxSelCsr layout is broken into a 9-beat, 8-bit configuration transfer addressed by DbmId. The transfer uses ready/valid backpressure, then waits for the addressed node's apply-acknowledge, with a timeout. It sits between the DFD CSR block and the debug-mux configuration bus, and is the only master of that bus.

## Interface
Parameters:
- NUM_DBM, 8: number of mux nodes on the chain (1..64); valid DbmId range 0..NUM_DBM-1.
- ACK_TIMEOUT, 255: maximum cycles spent in WAIT_ACK (1..65535).

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- clk  in  1  clock.
- reset_n  in  1  synchronous reset, active-low.
- csr_wr_valid  in  1  CSR write request.
- csr_wr_data  in  64  packed fields, MSB first:
  - [63:16] Muxselseg7..Muxselseg0, 6 bits each, seg0 at [21:16].
  - [15:8] reserved, ignored.
  - [7:2] DbmId.
  - [1:0] DbmMode.
- csr_wr_ready  out  1  high only in IDLE.
- cfg_valid  out  1  config beat valid.
- cfg_ready  in  1  chain accepts beat.
- cfg_id  out  6  target DbmId, constant for a transfer.
- cfg_beat  out  4  beat index 0..8.
- cfg_data  out  8  beat payload.
- cfg_last  out  1  final beat of transfer.
- node_ack  in  1  single-cycle pulse from addressed node: config applied.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on successful completion.
- active_idmode  out  8  {DbmId,DbmMode} of last successfully applied write.
- status_err  out  2  sticky: [0] ack timeout, [1] DbmId out of range.
- status_err_clr  in  1  clears status_err.

## Operation
- States: IDLE, SEND, WAIT_ACK.
- IDLE:
  - csr_wr_ready=1. A write is accepted when csr_wr_valid is high.
  - The write is latched into an internal 64-bit register.
  - If DbmId >= NUM_DBM: set status_err[1], stay IDLE, emit no beats, no done.
  - Otherwise go to SEND with beat counter 0.
- SEND:
  - cfg_valid=1.
  - cfg_data by beat:
    - beat 0 = {DbmId,DbmMode}.
    - beat k (1..8) = {2'b00, Muxselseg(k-1)}.
  - A beat transfers when cfg_valid and cfg_ready are both high. The counter then increments.
  - cfg_id, cfg_beat, cfg_data and cfg_last are held stable while cfg_valid=1 and cfg_ready=0.
  - DbmMode==2'b00 (disable): the transfer is beat 0 only, with cfg_last=1 on beat 0.
  - Otherwise cfg_last=1 on beat 8.
  - A transfer of the last beat goes to WAIT_ACK and clears the timeout counter.
- WAIT_ACK:
  - cfg_valid=0. The counter increments every cycle.
  - node_ack=1 → IDLE, done pulse, active_idmode updated.
  - No ack and counter == ACK_TIMEOUT-1 → IDLE, set status_err[0], no done, active_idmode unchanged.
  - If ack and timeout coincide, ack wins.
- node_ack outside WAIT_ACK is ignored.
- Error bits:
  - status_err_clr clears both bits.
  - If a set and a clear occur in the same cycle, the set wins for that bit.
- csr_wr_valid while not in IDLE is not accepted. The requester holds it; nothing is queued.

## Timing
- Reset values:
  - state=IDLE, csr_wr_ready=1.
  - cfg_valid, cfg_last, done, busy = 0.
  - cfg_id, cfg_beat, cfg_data = 0.
  - active_idmode=0, status_err=0, counters=0.
- All outputs are registered or decoded directly from registered state. There are no combinational input-to-output paths.
- Write accepted at edge T:
  - cfg_valid and beat 0 are visible in cycle T+1.
  - With cfg_ready held high, beats 0..8 occupy T+1..T+9 and WAIT_ACK starts at T+10.
  - In disable mode, WAIT_ACK starts at T+2.
- node_ack in cycle A:
  - In cycle A+1: done=1, busy=0, csr_wr_ready=1, active_idmode new.
- No ack: WAIT_ACK lasts exactly ACK_TIMEOUT cycles. status_err[0] and IDLE appear on the next cycle.
- Out-of-range write at edge T: status_err[1]=1 in T+1, and csr_wr_ready stays 1.
- Back-to-back writes: a new write can be accepted in the first IDLE cycle after done.
- reset_n low mid-transfer: at the next edge all state returns to reset values. cfg_valid drops with no cfg_last, and no done is issued.

## Test plan
- Normal write: DbmId=3, DbmMode=1, seg k = k+0x10, cfg_ready=1, ack 4 cycles after last beat.
  - 9 beats: data 0x0D, 0x10..0x17.
  - cfg_last on beat 8.
  - done one cycle after ack; active_idmode=0x0D.
- Backpressure: same write, cfg_ready toggled 1,0,0,1,…
  - Beat payloads are stable during stalls.
  - Exactly 9 transfers, in order, with no duplicates or drops.
- Disable mode: DbmId=5, DbmMode=0.
  - Single beat, 0x14, with cfg_last=1.
  - Ack leads to done.
- Timeout: ACK_TIMEOUT=4, never ack.
  - WAIT_ACK lasts 4 cycles, then status_err=2'b01 and IDLE.
  - No done; active_idmode unchanged.
- Bad ID: NUM_DBM=8, DbmId=9.
  - Write is accepted, status_err=2'b10, no cfg_valid.
  - status_err_clr → 0. Clear and a fresh bad ID in the same cycle → status_err[1] stays 1.
- Reset mid-transfer: reset_n low during beat 4, then released.
  - cfg_valid=0 and all outputs at reset values.
  - A new write completes normally.
